// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART command transmitter: the byte-sequencing
// state encoding, the frame length and the default bit period.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

  // Byte-sequencing states of the command transmitter.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // Start bit + 8 data bits + stop bit.
  localparam int FRAME_BITS = 10;

  // 50 MHz system clock / 19200 baud.
  localparam int BAUD_DIV_DEFAULT = 2604;

endpackage

// File: rtl/uart_cmd_tx_if.sv
// -----------------------------------------------------------------------------
// uart_cmd_tx_if
// Host-side command handshake of the UART command transmitter.
//   snd_cmd  host -> tx   single-cycle request to send cmd
//   cmd      host -> tx   16-bit command word, sampled on acceptance
//   busy     tx -> host   transfer in progress
//   cmd_snt  tx -> host   sticky "last command fully transmitted"
// Modports: master (host side), slave (transmitter side).
// -----------------------------------------------------------------------------
interface uart_cmd_tx_if;

  logic        snd_cmd;
  logic [15:0] cmd;
  logic        busy;
  logic        cmd_snt;

  modport master (
    output snd_cmd,
    output cmd,
    input  busy,
    input  cmd_snt
  );

  modport slave (
    input  snd_cmd,
    input  cmd,
    output busy,
    output cmd_snt
  );

endinterface

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Bit-level 8N1 UART transmitter. A trmt pulse loads {tx_data, start bit}
// into a 9-bit shift register; every BAUD_DIV cycles the register shifts
// right, filling with ones, so the stop bit and the idle level come for free.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   trmt     in   single-cycle load request (ignored mid-frame)
//   tx_data  in   byte to send, LSB first
//   TX       out  serial line, idle high
//   tx_done  out  single-cycle pulse on the last cycle of the stop bit
// -----------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done
);

  localparam int               CNT_W     = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [3:0]       STOP_IDX  = 4'(FRAME_BITS - 1);

  logic [8:0]       shift;
  logic [CNT_W-1:0] baud_cnt;
  logic [3:0]       bit_cnt;
  logic             active;
  logic             bit_end;
  logic             load;

  assign bit_end = active && (baud_cnt == BAUD_LAST);
  assign tx_done = bit_end && (bit_cnt == STOP_IDX);

  // A reload is allowed on the final stop-bit cycle so the next frame's start
  // bit follows the stop bit with no idle gap.
  assign load = trmt && (!active || tx_done);

  assign TX = shift[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift    <= '1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      active   <= 1'b0;
    end else if (load) begin
      shift    <= {tx_data, 1'b0};
      baud_cnt <= '0;
      bit_cnt  <= '0;
      active   <= 1'b1;
    end else if (bit_end) begin
      shift    <= {1'b1, shift[8:1]};
      baud_cnt <= '0;
      bit_cnt  <= bit_cnt + 4'd1;
      if (tx_done) begin
        active <= 1'b0;
      end
    end else if (active) begin
      baud_cnt <= baud_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_cmd_tx.sv
// -----------------------------------------------------------------------------
// uart_cmd_tx
// Sends a 16-bit command word as two back-to-back 8N1 UART frames, high byte
// first. The word is captured in a holding register on acceptance, so later
// changes on cmd do not affect the transfer in flight.
// Ports:
//   clk    in    system clock
//   rst_n  in    asynchronous active-low reset
//   host   slave uart_cmd_tx_if: snd_cmd/cmd in, busy/cmd_snt out
//   TX     out   serial line, idle high
// -----------------------------------------------------------------------------
module uart_cmd_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_cmd_tx_if.slave  host,
  output logic          TX
);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] held;
  logic        cmd_snt;
  logic        accept;
  logic        trmt;
  logic        set_snt;
  logic        tx_done;
  logic [7:0]  tx_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held    <= '0;
      cmd_snt <= 1'b0;
    end else if (accept) begin
      held    <= host.cmd;
      cmd_snt <= 1'b0;
    end else if (set_snt) begin
      cmd_snt <= 1'b1;
    end
  end

  // The high byte is taken straight from cmd on the accept cycle because the
  // holding register only captures it at that same edge.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    trmt      = 1'b0;
    set_snt   = 1'b0;
    tx_data   = held[7:0];
    case (state)
      IDLE: begin
        if (host.snd_cmd) begin
          accept    = 1'b1;
          trmt      = 1'b1;
          tx_data   = host.cmd[15:8];
          state_nxt = HIGH;
        end
      end
      HIGH: begin
        if (tx_done) begin
          trmt      = 1'b1;
          tx_data   = held[7:0];
          state_nxt = LOW;
        end
      end
      LOW: begin
        if (tx_done) begin
          set_snt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign host.busy    = (state != IDLE);
  assign host.cmd_snt = cmd_snt;

  uart_tx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .trmt    (trmt),
    .tx_data (tx_data),
    .TX      (TX),
    .tx_done (tx_done)
  );

endmodule
